adder_sweep_sequencer: RTL and testbench
========================================

# adder_sweep_sequencer

Sequencer sitting directly upstream of the instrumented adder. It replaces manual logic-analyzer bit-banging: it sweeps the ring-connected adder bit over a programmed range and runs one timed integration per bit. For each bit it returns the captured ring-oscillator count to the CPU through a valid/ready result port. It drives the adder's reset, load, enable, stop and bit-select controls, and consumes its `done` and ring counter outputs.

## Interface
Parameters:
- NUM_BITS, 8, adder width; bit-select vectors are NUM_BITS wide.
- COUNT_W, 32, width of integration time and ring count.
- SETTLE_CYCLES, 4, cycles the ring is held stopped before the count is sampled (≥1).

Ports (one clock; reset is asynchronous and active-low):
- wb_clk_i  in  1  system clock.
- wb_rst_n_i  in  1  asynchronous active-low reset.
- start  in  1  single-cycle sweep request; ignored unless IDLE.
- abort  in  1  level; forces IDLE next cycle.
- bit_first, bit_last  in  $clog2(NUM_BITS)  sweep range.
- integration_time  in  COUNT_W  passed to the adder; sampled at start.
- adder_done  in  1  adder integration counter reached zero.
- adder_ring_count  in  COUNT_W  adder ring_osc_counter_out.
- adder_reset  out  1  adder counter reset.
- adder_counter_load, adder_counter_enable  out  1 each.
- adder_stop_b  out  1  0 = ring stopped.
- adder_a_ring_bit_b, adder_s_bit_b  out  NUM_BITS  inverted one-hot bit selects.
- adder_integration_time  out  COUNT_W  latched integration_time.
- result_valid  out  1; result_ready  in  1.
- result_bit  out  $clog2(NUM_BITS); result_count  out  COUNT_W.
- busy  out  1  high whenever not IDLE.
- sweep_done  out  1  one-cycle pulse after the last result is accepted.

## Operation
- FSM states: IDLE, SETUP, LOAD, RUN, SETTLE, REPORT.
- IDLE → SETUP on start. On that transition, latch integration_time and set cur = bit_first.
- SETUP (1 cycle): adder_reset=1, stop_b=0. Select drives ~(1<<cur) on both bit-select outputs.
- LOAD (1 cycle): counter_load=1.
- RUN: stop_b=1, counter_enable=1. adder_done is ignored on the first RUN cycle. When adder_done is sampled high afterwards, go to SETTLE.
- SETTLE: stop_b=0, counter_enable=0. Stay for SETTLE_CYCLES cycles, then sample adder_ring_count into result_count and cur into result_bit, then go to REPORT.
- REPORT: result_valid=1. Outputs are held stable until result_ready. On the handshake:
  - if cur==bit_last, go to IDLE and pulse sweep_done;
  - otherwise cur = (cur+1) mod NUM_BITS, then go to SETUP.
- Wrap-around: if bit_first > bit_last, the sweep wraps. Example: first=6, last=1 measures 6,7,0,1. If first==last, exactly one measurement.
- Bit selects stay driven with the current bit from SETUP through REPORT. In IDLE they are all ones.
- abort or reset mid-operation: return to IDLE, with no result and no sweep_done. Any pending result_valid drops.
- start while busy is ignored. Simultaneous start and abort in IDLE: abort wins.

## Timing
- Reset/IDLE values:
  - adder_reset=0, load=0, enable=0, stop_b=0;
  - both bit-select outputs all ones;
  - adder_integration_time=0 after reset, otherwise holds its last latched value;
  - result_valid=0, result_bit=0, result_count=0;
  - busy=0, sweep_done=0.
- All outputs are registered.
- Cycle sequence:
  - start sampled at cycle 0 → SETUP at 1, LOAD at 2, RUN from 3.
  - adder_done sampled high at cycle k → stop_b low from k+1.
  - result_valid high at k+SETTLE_CYCLES+1.
- After the handshake cycle h: the next SETUP is at h+1, or sweep_done is high at h+1.
- integration_time=0 is legal. It completes after the minimum 2 RUN cycles.

## Configuration
- SWEEP_MINMAX_EN defined: adds outputs min_count and max_count (COUNT_W each) and min_bit and max_bit.
  - They are cleared at start: min to all ones, max to 0, bits to 0.
  - They are updated on each REPORT handshake. Ties keep the earlier bit.
  - They are valid when sweep_done pulses, and hold until the next start.
- Not defined: those ports and that logic are absent; nothing else changes.

## Structure
- Shared package: FSM state enum; the sweep_state_t typedef; NUM_BITS and COUNT_W defaults.
- One sub-module: sweep_bit_select. It converts cur plus an active flag into the two registered inverted one-hot vectors.

## Test plan
- first=2, last=2, time=100, adder model done after 100 cycles with count 0x1234 → one result (bit 2, 0x1234), sweep_done once, selects = 8'b11111011 during measurement.
- first=6, last=1 → results for bits 6,7,0,1 in order; sweep_done after the 4th handshake.
- result_ready held low 20 cycles in REPORT → result_valid, result_bit and result_count stable throughout; no next SETUP until the handshake.
- abort asserted during RUN → next cycle IDLE, stop_b=0, selects 8'hFF, no result_valid, no sweep_done.
- wb_rst_n_i asserted in SETTLE → immediate reset values; a subsequent start runs a clean sweep.
- SWEEP_MINMAX_EN defined, counts 50,30,30,90 for bits 0..3 → min_count 30/min_bit 1, max_count 90/max_bit 3.

Source files
------------

// File: rtl/adder_sweep_sequencer_pkg.sv
// Shared definitions for the adder sweep sequencer.
// Contents: default adder width / count width and the sequencer FSM state type.
package adder_sweep_sequencer_pkg;

  localparam int NUM_BITS_DEF = 8;
  localparam int COUNT_W_DEF  = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_LOAD,
    S_RUN,
    S_SETTLE,
    S_REPORT
  } sweep_state_t;

endpackage

// File: rtl/adder_sweep_sequencer_if.sv
// Result port of the adder sweep sequencer (valid/ready handshake).
// Signals: result_valid, result_bit, result_count (sequencer -> CPU),
//          result_ready (CPU -> sequencer).
// Modports: master = sequencer side, slave = consumer side.
interface adder_sweep_sequencer_if
  import adder_sweep_sequencer_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF,
  parameter int COUNT_W  = COUNT_W_DEF
);
  logic                        result_valid;
  logic                        result_ready;
  logic [$clog2(NUM_BITS)-1:0] result_bit;
  logic [COUNT_W-1:0]          result_count;

  modport master (output result_valid, output result_bit, output result_count,
                  input  result_ready);
  modport slave  (input  result_valid, input  result_bit, input  result_count,
                  output result_ready);
endinterface

// File: rtl/adder_sweep_sequencer_bit_select.sv
// sweep_bit_select: registered inverted one-hot bit selects for the adder.
// Ports: clk, rst_n (async active-low); cur = bit index; active = drive a
//        select (otherwise all ones); a_ring_bit_b, s_bit_b = identical
//        registered inverted one-hot outputs.
module sweep_bit_select
  import adder_sweep_sequencer_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [$clog2(NUM_BITS)-1:0] cur,
  input  logic                        active,
  output logic [NUM_BITS-1:0]         a_ring_bit_b,
  output logic [NUM_BITS-1:0]         s_bit_b
);

  logic [NUM_BITS-1:0] sel_b;

  always_comb begin
    sel_b = '1;
    if (active) sel_b[cur] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ring_bit_b <= '1;
      s_bit_b      <= '1;
    end else begin
      a_ring_bit_b <= sel_b;
      s_bit_b      <= sel_b;
    end
  end

endmodule

// File: rtl/adder_sweep_sequencer.sv
// adder_sweep_sequencer: sweeps the ring-connected adder bit from bit_first to
// bit_last (wrapping mod NUM_BITS), runs one timed integration per bit and
// returns each captured ring count on the result interface.
// Ports: wb_clk_i, wb_rst_n_i (async active-low); start/abort control;
//        bit_first/bit_last/integration_time configuration; adder_done and
//        adder_ring_count from the adder; adder_* controls to the adder;
//        result (valid/ready master); busy; sweep_done pulse.
// Optional: SWEEP_MINMAX_EN adds min_count/max_count/min_bit/max_bit.
// All outputs are registered from the next-state decode so they line up with
// the state they belong to.
module adder_sweep_sequencer
  import adder_sweep_sequencer_pkg::*;
#(
  parameter int NUM_BITS      = NUM_BITS_DEF,
  parameter int COUNT_W       = COUNT_W_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_n_i,
  input  logic                        start,
  input  logic                        abort,
  input  logic [$clog2(NUM_BITS)-1:0] bit_first,
  input  logic [$clog2(NUM_BITS)-1:0] bit_last,
  input  logic [COUNT_W-1:0]          integration_time,
  input  logic                        adder_done,
  input  logic [COUNT_W-1:0]          adder_ring_count,
  output logic                        adder_reset,
  output logic                        adder_counter_load,
  output logic                        adder_counter_enable,
  output logic                        adder_stop_b,
  output logic [NUM_BITS-1:0]         adder_a_ring_bit_b,
  output logic [NUM_BITS-1:0]         adder_s_bit_b,
  output logic [COUNT_W-1:0]          adder_integration_time,
  adder_sweep_sequencer_if.master     result,
  output logic                        busy,
  output logic                        sweep_done
`ifdef SWEEP_MINMAX_EN
  ,
  output logic [COUNT_W-1:0]          min_count,
  output logic [COUNT_W-1:0]          max_count,
  output logic [$clog2(NUM_BITS)-1:0] min_bit,
  output logic [$clog2(NUM_BITS)-1:0] max_bit
`endif
);

  localparam int BIT_W = $clog2(NUM_BITS);
  localparam int SC_W  = $clog2(SETTLE_CYCLES + 1);

  sweep_state_t      state, state_nx;
  logic [BIT_W-1:0]  cur, cur_nx, last_q;
  logic [SC_W-1:0]   settle_cnt;
  logic              run_first;
  logic              hs, done_nx, start_ok;

  assign hs       = (state == S_REPORT) && result.result_ready;
  assign start_ok = (state == S_IDLE) && start && !abort;

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    done_nx  = 1'b0;
    case (state)
      S_IDLE:   if (start) begin
                  state_nx = S_SETUP;
                  cur_nx   = bit_first;
                end
      S_SETUP:  state_nx = S_LOAD;
      S_LOAD:   state_nx = S_RUN;
      // adder_done may still reflect the previous count on the first RUN cycle
      S_RUN:    if (!run_first && adder_done) state_nx = S_SETTLE;
      S_SETTLE: if (settle_cnt == SC_W'(SETTLE_CYCLES - 1)) state_nx = S_REPORT;
      S_REPORT: if (hs) begin
                  if (cur == last_q) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                  end else begin
                    state_nx = S_SETUP;
                    cur_nx   = (cur == BIT_W'(NUM_BITS - 1)) ? '0 : BIT_W'(cur + 1'b1);
                  end
                end
      default:  state_nx = S_IDLE;
    endcase
    if (abort) begin
      state_nx = S_IDLE;
      cur_nx   = cur;
      done_nx  = 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state                  <= S_IDLE;
      cur                    <= '0;
      last_q                 <= '0;
      settle_cnt             <= '0;
      run_first              <= 1'b0;
      adder_reset            <= 1'b0;
      adder_counter_load     <= 1'b0;
      adder_counter_enable   <= 1'b0;
      adder_stop_b           <= 1'b0;
      adder_integration_time <= '0;
      busy                   <= 1'b0;
      sweep_done             <= 1'b0;
      result.result_valid    <= 1'b0;
      result.result_bit      <= '0;
      result.result_count    <= '0;
    end else begin
      state                <= state_nx;
      cur                  <= cur_nx;
      adder_reset          <= (state_nx == S_SETUP);
      adder_counter_load   <= (state_nx == S_LOAD);
      adder_counter_enable <= (state_nx == S_RUN);
      adder_stop_b         <= (state_nx == S_RUN);
      busy                 <= (state_nx != S_IDLE);
      sweep_done           <= done_nx;
      result.result_valid  <= (state_nx == S_REPORT);
      run_first            <= (state_nx == S_RUN) && (state != S_RUN);
      settle_cnt           <= (state == S_SETTLE) ? SC_W'(settle_cnt + 1'b1) : '0;
      if (start_ok) begin
        adder_integration_time <= integration_time;
        last_q                 <= bit_last;
      end
      if (state_nx == S_IDLE) begin
        result.result_bit   <= '0;
        result.result_count <= '0;
      end else if ((state == S_SETTLE) && (state_nx == S_REPORT)) begin
        result.result_bit   <= cur;
        result.result_count <= adder_ring_count;
      end
    end
  end

  // Selects are registered from next-state values so they change with the FSM.
  sweep_bit_select #(.NUM_BITS(NUM_BITS)) u_bit_select (
    .clk          (wb_clk_i),
    .rst_n        (wb_rst_n_i),
    .cur          (cur_nx),
    .active       (state_nx != S_IDLE),
    .a_ring_bit_b (adder_a_ring_bit_b),
    .s_bit_b      (adder_s_bit_b)
  );

`ifdef SWEEP_MINMAX_EN
  logic mm_empty;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      min_count <= '1;
      max_count <= '0;
      min_bit   <= '0;
      max_bit   <= '0;
      mm_empty  <= 1'b1;
    end else if (start_ok) begin
      min_count <= '1;
      max_count <= '0;
      min_bit   <= '0;
      max_bit   <= '0;
      mm_empty  <= 1'b1;
    end else if (hs && !abort) begin
      mm_empty <= 1'b0;
      // strict compares keep the earlier bit on ties
      if (mm_empty || (result.result_count < min_count)) begin
        min_count <= result.result_count;
        min_bit   <= result.result_bit;
      end
      if (mm_empty || (result.result_count > max_count)) begin
        max_count <= result.result_count;
        max_bit   <= result.result_bit;
      end
    end
  end
`endif

endmodule

// File: tb/tb_adder_sweep_sequencer.sv
// Self-checking bench for adder_sweep_sequencer: behavioural adder model,
// result scoreboard, and directed sweep / stall / abort / reset scenarios.
// Optional checks for SWEEP_MINMAX_EN when that macro is defined.
module tb_adder_sweep_sequencer;

  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [2:0]  bit_first = '0;
  logic [2:0]  bit_last = '0;
  logic [31:0] integration_time = '0;
  logic        adder_done;
  logic [31:0] adder_ring_count;
  logic        adder_reset, adder_counter_load, adder_counter_enable, adder_stop_b;
  logic [7:0]  adder_a_ring_bit_b, adder_s_bit_b;
  logic [31:0] adder_integration_time;
  logic        busy, sweep_done;
`ifdef SWEEP_MINMAX_EN
  logic [31:0] min_count, max_count;
  logic [2:0]  min_bit, max_bit;
`endif

  adder_sweep_sequencer_if #(.NUM_BITS(8), .COUNT_W(32)) ifc ();

  adder_sweep_sequencer #(.NUM_BITS(8), .COUNT_W(32), .SETTLE_CYCLES(SETTLE)) dut (
    .wb_clk_i               (clk),
    .wb_rst_n_i             (rst_n),
    .start                  (start),
    .abort                  (abort),
    .bit_first              (bit_first),
    .bit_last               (bit_last),
    .integration_time       (integration_time),
    .adder_done             (adder_done),
    .adder_ring_count       (adder_ring_count),
    .adder_reset            (adder_reset),
    .adder_counter_load     (adder_counter_load),
    .adder_counter_enable   (adder_counter_enable),
    .adder_stop_b           (adder_stop_b),
    .adder_a_ring_bit_b     (adder_a_ring_bit_b),
    .adder_s_bit_b          (adder_s_bit_b),
    .adder_integration_time (adder_integration_time),
    .result                 (ifc),
    .busy                   (busy),
    .sweep_done             (sweep_done)
`ifdef SWEEP_MINMAX_EN
    ,
    .min_count              (min_count),
    .max_count              (max_count),
    .min_bit                (min_bit),
    .max_bit                (max_bit)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Adder model: load on counter_load, count down while enabled, done at zero.
  logic [31:0] ring_tbl [8];
  logic [31:0] model_cnt = '0;
  logic [2:0]  sel_idx;

  always @(posedge clk) begin
    if (adder_counter_load) model_cnt <= adder_integration_time;
    else if (adder_counter_enable && model_cnt != 0) model_cnt <= model_cnt - 1;
  end
  assign adder_done = adder_counter_enable && (model_cnt == 0);

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < 8; i++) if (!adder_a_ring_bit_b[i]) sel_idx = 3'(i);
    adder_ring_count = ring_tbl[sel_idx];
  end

  typedef struct { logic [2:0] b; logic [31:0] c; } exp_t;
  exp_t sb[$];
  int done_cnt = 0;
  int en_cnt = 0;

  // Scoreboard / monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.result_valid && ifc.result_ready) begin
        if (sb.size() == 0) check("result_unexpected", ifc.result_valid, 1'b0);
        else begin
          exp_t e;
          e = sb.pop_front();
          check("result_bit", ifc.result_bit, e.b);
          check("result_count", ifc.result_count, e.c);
        end
      end
      if (sweep_done) begin
        done_cnt++;
        check("done_after_last_result", sb.size(), 0);
      end
      if (adder_counter_enable) en_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [2:0] f, input logic [2:0] l,
                             input logic [31:0] t, input bit push);
    logic [2:0] b;
    exp_t e;
    bit_first = f;
    bit_last = l;
    integration_time = t;
    if (push) begin
      b = f;
      for (int n = 0; n < 8; n++) begin
        e.b = b;
        e.c = ring_tbl[b];
        sb.push_back(e);
        if (b == l) break;
        b = b + 3'd1;
      end
    end
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget && done_cnt == d0; i++) tick();
    check(tag, done_cnt - d0, 1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    for (int i = 0; i < budget && !ifc.result_valid; i++) tick();
    check(tag, ifc.result_valid, 1'b1);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_stop_b"}, adder_stop_b, 1'b0);
    check({tag, "_enable"}, adder_counter_enable, 1'b0);
    check({tag, "_a_sel"}, adder_a_ring_bit_b, 8'hFF);
    check({tag, "_s_sel"}, adder_s_bit_b, 8'hFF);
    check({tag, "_valid"}, ifc.result_valid, 1'b0);
    check({tag, "_sweep_done"}, sweep_done, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, e0;
    for (int i = 0; i < 8; i++) ring_tbl[i] = 32'h100 * i + 32'h11;
    ring_tbl[2] = 32'h1234;
    ifc.result_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_idle("rst");
    check("rst_int_time", adder_integration_time, 32'd0);
    check("rst_result_bit", ifc.result_bit, 3'd0);
    check("rst_result_count", ifc.result_count, 32'd0);
    check("rst_adder_reset", adder_reset, 1'b0);
    check("rst_load", adder_counter_load, 1'b0);
    rst_n = 1'b1;
    tick();

    // Single bit, cycle-accurate sequence
    start_sweep(3'd2, 3'd2, 32'd100, 1'b1);
    check("t1_setup_reset", adder_reset, 1'b1);
    check("t1_setup_stop_b", adder_stop_b, 1'b0);
    check("t1_setup_a_sel", adder_a_ring_bit_b, 8'b11111011);
    check("t1_setup_s_sel", adder_s_bit_b, 8'b11111011);
    check("t1_busy", busy, 1'b1);
    check("t1_int_time", adder_integration_time, 32'd100);
    tick();
    check("t1_load", adder_counter_load, 1'b1);
    check("t1_load_reset_off", adder_reset, 1'b0);
    tick();
    check("t1_run_enable", adder_counter_enable, 1'b1);
    check("t1_run_stop_b", adder_stop_b, 1'b1);
    for (int i = 0; i < 200 && !adder_done; i++) tick();
    check("t1_adder_done_seen", adder_done, 1'b1);
    tick();
    check("t1_settle_stop_b", adder_stop_b, 1'b0);
    check("t1_settle_enable", adder_counter_enable, 1'b0);
    check("t1_settle_a_sel", adder_a_ring_bit_b, 8'b11111011);
    repeat (SETTLE - 1) tick();
    check("t1_valid_not_early", ifc.result_valid, 1'b0);
    tick();
    check("t1_valid_on_time", ifc.result_valid, 1'b1);
    check("t1_report_a_sel", adder_a_ring_bit_b, 8'b11111011);
    d0 = done_cnt;
    tick();
    check("t1_sweep_done_pulse", sweep_done, 1'b1);
    check("t1_valid_drop", ifc.result_valid, 1'b0);
    tick();
    check("t1_sweep_done_once", done_cnt - d0, 1);
    check_idle("t1_end");
    check("t1_int_time_hold", adder_integration_time, 32'd100);

    // Wrap-around sweep with a start pulse while busy
    start_sweep(3'd6, 3'd1, 32'd5, 1'b1);
    repeat (3) tick();
    bit_first = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t2_wrap_done", 300);
    check("t2_sb_empty", sb.size(), 0);

    // Stalled consumer
    ifc.result_ready = 1'b0;
    start_sweep(3'd3, 3'd4, 32'd2, 1'b1);
    wait_valid("t3_first_valid", 100);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("t3_stall_valid", ifc.result_valid, 1'b1);
      check("t3_stall_bit", ifc.result_bit, 3'd3);
      check("t3_stall_count", ifc.result_count, ring_tbl[3]);
      check("t3_stall_no_setup", adder_reset, 1'b0);
    end
    ifc.result_ready = 1'b1;
    wait_done("t3_stall_done", 200);
    check("t3_sb_empty", sb.size(), 0);

    // Abort during RUN
    d0 = done_cnt;
    start_sweep(3'd5, 3'd7, 32'd50, 1'b0);
    repeat (5) tick();
    check("t4_in_run", adder_counter_enable, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle("t4_abort");
    repeat (120) tick();
    check("t4_no_sweep_done", done_cnt - d0, 0);
    check("t4_still_idle", busy, 1'b0);

    // Start and abort together in IDLE
    start = 1'b1;
    abort = 1'b1;
    bit_first = 3'd0;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("t4b_abort_wins", busy, 1'b0);

    // Zero integration time: two RUN cycles
    e0 = en_cnt;
    start_sweep(3'd5, 3'd5, 32'd0, 1'b1);
    wait_done("t5_zero_time_done", 100);
    check("t5_run_cycles", en_cnt - e0, 2);

    // Reset asserted in SETTLE, then a clean sweep
    start_sweep(3'd1, 3'd2, 32'd3, 1'b0);
    for (int i = 0; i < 50 && !adder_done; i++) tick();
    check("t6_adder_done_seen", adder_done, 1'b1);
    tick();
    check("t6_in_settle", adder_stop_b, 1'b0);
    rst_n = 1'b0;
    #1;
    check_idle("t6_rst");
    check("t6_rst_int_time", adder_integration_time, 32'd0);
    check("t6_rst_count", ifc.result_count, 32'd0);
    #1;
    rst_n = 1'b1;
    tick();
    start_sweep(3'd0, 3'd1, 32'd4, 1'b1);
    wait_done("t6_clean_done", 200);
    check("t6_sb_empty", sb.size(), 0);

`ifdef SWEEP_MINMAX_EN
    ring_tbl[0] = 32'd50;
    ring_tbl[1] = 32'd30;
    ring_tbl[2] = 32'd30;
    ring_tbl[3] = 32'd90;
    start_sweep(3'd0, 3'd3, 32'd3, 1'b1);
    wait_done("mm_done", 300);
    check("mm_min_count", min_count, 32'd30);
    check("mm_min_bit", min_bit, 3'd1);
    check("mm_max_count", max_count, 32'd90);
    check("mm_max_bit", max_bit, 3'd3);
`endif

    repeat (3) tick();
    check("final_sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
